// File: rtl/light_pkg.sv
// Shared definitions for the lighting scheduler: lamp state encoding,
// command polarity, counter width and requester port indices.
package light_pkg;

    // Lamp FSM encoding; this code is also driven out on lampstate.
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_WARN = 2'b10
    } lamp_state_t;

    // Command polarity carried on btn_cmd / kp_cmd.
    localparam logic CMD_ON  = 1'b1;
    localparam logic CMD_OFF = 1'b0;

    // Width of the vacancy and warn counters.
    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

    // Bit positions of the two requesters in the arbiter vectors.
    localparam int PORT_BTN = 0;
    localparam int PORT_KP  = 1;

endpackage

// File: rtl/light_scheduler_if.sv
// Request/command/grant handshake between the two command sources
// (wall button and keypad) and the lighting scheduler.
interface light_scheduler_if;

    logic btn_req;
    logic btn_cmd;
    logic kp_req;
    logic kp_cmd;
    logic btn_grant;
    logic kp_grant;

    // Requester side: raises req with a cmd and holds both until granted.
    modport master (
        output btn_req,
        output btn_cmd,
        output kp_req,
        output kp_cmd,
        input  btn_grant,
        input  kp_grant
    );

    // Scheduler side: samples requests and returns one-cycle grants.
    modport slave (
        input  btn_req,
        input  btn_cmd,
        input  kp_req,
        input  kp_cmd,
        output btn_grant,
        output kp_grant
    );

endinterface

// File: rtl/light_rr_arbiter.sv
// Two-port round-robin arbiter with registered one-cycle grants.
// A port that holds a grant this cycle is not eligible on the next edge,
// so a request still held after its grant is re-arbitrated as a new one.
module light_rr_arbiter
    import light_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic       prio_kp;   // 1: keypad wins a tie, 0: button wins a tie
    logic [1:0] elig;
    logic [1:0] grant_nxt;

    // Pick at most one eligible requester, breaking ties by the pointer.
    always_comb begin
        elig      = req & ~grant;
        grant_nxt = 2'b00;
        case (elig)
            2'b01:   grant_nxt[PORT_BTN] = 1'b1;
            2'b10:   grant_nxt[PORT_KP]  = 1'b1;
            2'b11: begin
                if (prio_kp) grant_nxt[PORT_KP]  = 1'b1;
                else         grant_nxt[PORT_BTN] = 1'b1;
            end
            default: grant_nxt = 2'b00;
        endcase
    end

    // Register the grant and hand priority to the port that just lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= 2'b00;
            prio_kp <= 1'b0;
        end else begin
            grant <= grant_nxt;
            if (grant_nxt[PORT_BTN])     prio_kp <= 1'b1;
            else if (grant_nxt[PORT_KP]) prio_kp <= 1'b0;
        end
    end

endmodule

// File: rtl/light_scheduler.sv
// Room lighting scheduler: arbitrates wall-button and keypad commands,
// runs the OFF/ON/WARN lamp FSM with vacancy and warn countdown timers,
// and drives registered lamp/warn outputs decoded from the state.
module light_scheduler
    import light_pkg::*;
#(
    parameter int AUTO_OFF_CYCLES = 20,  // vacant cycles in ON before WARN (1..255)
    parameter int WARN_CYCLES     = 5    // cycles in WARN before lamp off (1..255)
) (
    input  logic                clk,
    input  logic                reset,      // asynchronous, active-low
    light_scheduler_if.slave    bus,
    input  logic                occupied,
    output logic                lamp_on,
    output logic                warn,
    output logic [1:0]          lampstate
);

    localparam cnt_t AUTO_CNT = cnt_t'(AUTO_OFF_CYCLES);
    localparam cnt_t WARN_CNT = cnt_t'(WARN_CYCLES);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        if (v == '1) return v;
        return v + cnt_t'(1);
    endfunction

    // Saturating decrement: holds at zero instead of wrapping.
    function automatic cnt_t sat_dec(input cnt_t v);
        if (v == '0) return v;
        return v - cnt_t'(1);
    endfunction

    logic        rst_sync_p0;
    logic        rst_sync_p1;
    logic        rst_n;

    logic [1:0]  req;
    logic [1:0]  grant_p0;
    logic        btn_cmd_p0;
    logic        kp_cmd_p0;

    logic        cmd_sel;
    logic        cmd_on;
    logic        cmd_off;

    lamp_state_t state;
    lamp_state_t state_nxt;
    cnt_t        vac_cnt;
    cnt_t        vac_nxt;
    cnt_t        wrn_cnt;
    cnt_t        wrn_nxt;

    // Reset synchroniser: assert immediately, release on the second clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            rst_sync_p1 <= rst_sync_p0;
        end
    end

    assign rst_n = rst_sync_p1;

    // ---- stage p0: arbitration and command capture ----
    assign req[PORT_BTN] = bus.btn_req;
    assign req[PORT_KP]  = bus.kp_req;

    light_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant_p0)
    );

    assign bus.btn_grant = grant_p0[PORT_BTN];
    assign bus.kp_grant  = grant_p0[PORT_KP];

    // Sample both commands on every edge; the registered grant selects the
    // one that was captured alongside it, so no reset is needed here.
    always_ff @(posedge clk) begin
        btn_cmd_p0 <= bus.btn_cmd;
        kp_cmd_p0  <= bus.kp_cmd;
    end

    // ---- stage p1: lamp FSM applies the granted command ----
    // Next-state and counter logic; a command always beats occupancy/timers.
    always_comb begin
        cmd_sel   = grant_p0[PORT_KP] ? kp_cmd_p0 : btn_cmd_p0;
        cmd_on    = (|grant_p0) && (cmd_sel == CMD_ON);
        cmd_off   = (|grant_p0) && (cmd_sel == CMD_OFF);
        state_nxt = state;
        vac_nxt   = vac_cnt;
        wrn_nxt   = wrn_cnt;
        case (state)
            ST_OFF: begin
                if (cmd_on) begin
                    state_nxt = ST_ON;
                    vac_nxt   = '0;
                end
            end
            ST_ON: begin
                if (cmd_off) begin
                    state_nxt = ST_OFF;
                end else if (cmd_on || occupied) begin
                    vac_nxt = '0;
                end else begin
                    vac_nxt = sat_inc(vac_cnt);
                    if (vac_nxt >= AUTO_CNT) begin
                        state_nxt = ST_WARN;
                        wrn_nxt   = WARN_CNT;
                    end
                end
            end
            ST_WARN: begin
                if (cmd_off) begin
                    state_nxt = ST_OFF;
                end else if (cmd_on || occupied) begin
                    state_nxt = ST_ON;
                    vac_nxt   = '0;
                end else begin
                    wrn_nxt = sat_dec(wrn_cnt);
                    if (wrn_nxt == '0) state_nxt = ST_OFF;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // State, counters and decoded outputs, all updated on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            vac_cnt <= '0;
            wrn_cnt <= '0;
            lamp_on <= 1'b0;
            warn    <= 1'b0;
        end else begin
            state   <= state_nxt;
            vac_cnt <= vac_nxt;
            wrn_cnt <= wrn_nxt;
            lamp_on <= (state_nxt != ST_OFF);
            warn    <= (state_nxt == ST_WARN);
        end
    end

    assign lampstate = state;

endmodule

// File: tb/tb_light_scheduler.sv
// Self-checking bench for light_scheduler: directed vector table,
// hand-written timer/reset sequences, and randomized traffic against
// a behavioural model of the arbiter and lamp rules.
module tb_light_scheduler;

    localparam int AUTO  = 20;
    localparam int WARNC = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       occupied;
    logic       lamp_on;
    logic       warn;
    logic [1:0] lampstate;
    logic [5:0] dut_o;

    light_scheduler_if bus();

    light_scheduler #(
        .AUTO_OFF_CYCLES (AUTO),
        .WARN_CYCLES     (WARNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .occupied  (occupied),
        .lamp_on   (lamp_on),
        .warn      (warn),
        .lampstate (lampstate)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {btn_grant, kp_grant, lamp_on, warn, lampstate}.
    assign dut_o = {bus.btn_grant, bus.kp_grant, lamp_on, warn, lampstate};

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural reference model ----------------
    int m_mode;      // 0 off, 1 on, 2 warn
    int m_idle;      // vacant cycles seen in ON
    int m_left;      // cycles remaining in WARN
    bit m_gb, m_gk;  // grants visible after the last edge
    bit m_turn_kp;   // keypad has the tie-break
    bit m_pend_vld, m_pend_on;

    task automatic model_reset();
        m_mode = 0; m_idle = 0; m_left = 0;
        m_gb = 0; m_gk = 0; m_turn_kp = 0;
        m_pend_vld = 0; m_pend_on = 0;
    endtask

    task automatic model_step(input bit br, input bit bc, input bit kr,
                              input bit kc, input bit occ);
        bit have, on, eb, ek, nb, nk;
        have = m_pend_vld;
        on   = m_pend_on;
        eb = br && !m_gb;
        ek = kr && !m_gk;
        nb = 0; nk = 0;
        if (eb && ek) begin
            if (m_turn_kp) nk = 1; else nb = 1;
        end else begin
            nb = eb; nk = ek;
        end
        if (nb) m_turn_kp = 1;
        if (nk) m_turn_kp = 0;
        m_pend_vld = nb || nk;
        m_pend_on  = nb ? bc : kc;
        m_gb = nb; m_gk = nk;
        case (m_mode)
            0: if (have && on) begin m_mode = 1; m_idle = 0; end
            1: begin
                if (have && !on) m_mode = 0;
                else if ((have && on) || occ) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle >= AUTO) begin m_mode = 2; m_left = WARNC; end
                end
            end
            default: begin
                if (have && !on) m_mode = 0;
                else if ((have && on) || occ) begin m_mode = 1; m_idle = 0; end
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        endcase
    endtask

    function automatic logic [5:0] model_out();
        logic [1:0] st;
        st = 2'(m_mode);
        return {m_gb, m_gk, (m_mode != 0), (m_mode == 2), st};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (bg kg lamp warn st)", nm, act, exp);
        end
    endtask

    task automatic chk_n(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d cycles expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs (just after a falling edge), step the model,
    // and return aligned to the next falling edge for sampling.
    task automatic apply(input bit br, input bit bc, input bit kr,
                         input bit kc, input bit occ);
        bus.btn_req = br; bus.btn_cmd = bc;
        bus.kp_req  = kr; bus.kp_cmd  = kc;
        occupied    = occ;
        model_step(br, bc, kr, kc, occ);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.btn_req = 0; bus.btn_cmd = 0;
        bus.kp_req  = 0; bus.kp_cmd  = 0;
        occupied    = 0;
        reset       = 1'b0;
        model_reset();
        @(negedge clk);
        release_reset();
    endtask

    task automatic wait_warn(input string nm, input int exp_n);
        int n;
        n = 0;
        do begin
            apply(0, 0, 0, 0, 0);
            n++;
        end while (!warn && n < 3 * AUTO);
        chk_n(nm, n, exp_n);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit br, bc, kr, kc, occ;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input bit br, input bit bc, input bit kr,
                                input bit kc, input bit occ, input logic [5:0] e);
        vec_t v;
        v.br = br; v.bc = bc; v.kr = kr; v.kc = kc; v.occ = occ; v.exp = e;
        return v;
    endfunction

    initial begin
        int n;
        bit br, bc, kr, kc, occ;

        tbl[0]  = mk(0, 0, 0, 0, 0, 6'b000000);  // idle after reset
        tbl[1]  = mk(1, 1, 0, 0, 0, 6'b100000);  // btn on: grant next cycle
        tbl[2]  = mk(0, 0, 0, 0, 0, 6'b001001);  // lamp on two cycles after req
        tbl[3]  = mk(0, 0, 0, 0, 1, 6'b001001);
        tbl[4]  = mk(1, 1, 1, 0, 0, 6'b011001);  // tie: kp wins after btn
        tbl[5]  = mk(1, 1, 0, 0, 0, 6'b100000);  // kp off applied; btn re-granted
        tbl[6]  = mk(0, 0, 0, 0, 0, 6'b001001);  // btn on applied
        tbl[7]  = mk(0, 0, 1, 1, 1, 6'b011001);
        tbl[8]  = mk(0, 0, 1, 1, 0, 6'b001001);  // held req: no back-to-back grant
        tbl[9]  = mk(0, 0, 1, 0, 0, 6'b011001);  // held req regranted as new
        tbl[10] = mk(0, 0, 0, 0, 0, 6'b000000);  // kp off applied
        tbl[11] = mk(0, 0, 1, 0, 0, 6'b010000);
        tbl[12] = mk(0, 0, 0, 0, 0, 6'b000000);  // off while OFF: no effect
        tbl[13] = mk(1, 0, 1, 1, 0, 6'b100000);  // tie: btn wins after kp
        tbl[14] = mk(0, 0, 1, 1, 0, 6'b010000);
        tbl[15] = mk(0, 0, 0, 0, 0, 6'b001001);  // kp on applied

        bus.btn_req = 0; bus.btn_cmd = 0;
        bus.kp_req  = 0; bus.kp_cmd  = 0;
        occupied    = 0;
        model_reset();

        // Reset state while reset is held low.
        #1 reset = 1'b0;
        #2 chk("reset_state", dut_o, 6'b000000);
        @(negedge clk);
        chk("reset_state_clk", dut_o, 6'b000000);
        release_reset();

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].br, tbl[i].bc, tbl[i].kr, tbl[i].kc, tbl[i].occ);
            chk($sformatf("tbl%0d", i), dut_o, tbl[i].exp);
        end

        // Auto-off timing: WARN after AUTO vacant cycles, OFF WARNC later.
        do_reset();
        apply(1, 1, 0, 0, 0);
        chk("auto_grant", dut_o, 6'b100000);
        apply(0, 0, 0, 0, 0);
        chk("auto_on", dut_o, 6'b001001);
        wait_warn("warn_delay", AUTO);
        chk("warn_state", dut_o, 6'b001110);
        n = 0;
        do begin
            apply(0, 0, 0, 0, 0);
            n++;
        end while (lamp_on && n < 4 * WARNC);
        chk_n("warn_len", n, WARNC);
        chk("warn_expired", dut_o, 6'b000000);

        // Occupancy during WARN returns to ON and restarts the full vacancy.
        apply(1, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        wait_warn("warn_delay2", AUTO);
        apply(0, 0, 0, 0, 1);
        chk("occ_rescue", dut_o, 6'b001001);
        wait_warn("rearm_delay", AUTO);

        // Off-command arriving on the edge the vacancy timer would expire.
        apply(0, 0, 0, 0, 1);
        chk("occ_rescue2", dut_o, 6'b001001);
        repeat (AUTO - 2) apply(0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        chk("race_grant", dut_o, 6'b011001);
        apply(0, 0, 0, 0, 0);
        chk("race_off", dut_o, 6'b000000);
        apply(0, 0, 0, 0, 0);
        chk("race_stays_off", dut_o, 6'b000000);

        // Asynchronous reset mid-WARN while a grant is outstanding.
        apply(1, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        wait_warn("warn_delay3", AUTO);
        apply(0, 0, 0, 0, 0);
        bus.btn_req = 1; bus.btn_cmd = 1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("rst_async", dut_o, 6'b000000);
        @(negedge clk);
        chk("rst_held", dut_o, 6'b000000);
        model_reset();
        bus.btn_req = 0; bus.btn_cmd = 0;
        release_reset();
        apply(0, 0, 0, 0, 0);
        chk("rst_cmd_lost", dut_o, 6'b000000);
        apply(1, 0, 1, 1, 0);
        chk("rst_ptr_btn", dut_o, 6'b100000);
        apply(0, 0, 1, 1, 0);
        chk("rst_kp_next", dut_o, 6'b010000);
        apply(0, 0, 0, 0, 0);
        chk("rst_kp_on", dut_o, 6'b001001);

        // Randomized traffic against the model.
        do_reset();
        br = 0; bc = 0; kr = 0; kc = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rand", dut_o, model_out());
            if (br) begin
                if (m_gb) begin
                    if ($urandom_range(7) != 0) br = 0;
                    else bc = 1'($urandom_range(1));
                end
            end else if ($urandom_range(39) == 0) begin
                br = 1; bc = 1'($urandom_range(1));
            end
            if (kr) begin
                if (m_gk) begin
                    if ($urandom_range(7) != 0) kr = 0;
                    else kc = 1'($urandom_range(1));
                end
            end else if ($urandom_range(39) == 0) begin
                kr = 1; kc = 1'($urandom_range(1));
            end
            occ = ($urandom_range(15) == 0);
            apply(br, bc, kr, kc, occ);
        end
        chk("rand_final", dut_o, model_out());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
